// File: rtl/seq_mem_rr_arbiter_if.sv
// Bundles the two-requester request/response channels and the single-port memory bus
// that seq_mem_rr_arbiter sits between.
interface seq_mem_rr_arbiter_if #(
  parameter int WIDTH    = 32,
  parameter int IDX_SIZE = 8
);
  logic [1:0]            req_valid;
  logic [1:0]            req_ready;
  logic [1:0]            req_write;
  logic [2*IDX_SIZE-1:0] req_addr;
  logic [2*WIDTH-1:0]    req_wdata;
  logic [1:0]            resp_valid;
  logic [1:0]            resp_ready;
  logic [WIDTH-1:0]      resp_rdata;
  logic                  resp_err;
  logic [IDX_SIZE-1:0]   mem_addr0;
  logic                  mem_read_en;
  logic                  mem_write_en;
  logic [WIDTH-1:0]      mem_in;
  logic [WIDTH-1:0]      mem_out;
  logic                  mem_read_done;
  logic                  mem_write_done;

  // The arbiter is the slave of the requesters and the master of the memory.
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
           mem_out, mem_read_done, mem_write_done,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_addr0, mem_read_en, mem_write_en, mem_in
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
           mem_out, mem_read_done, mem_write_done,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_addr0, mem_read_en, mem_write_en, mem_in
  );
endinterface

// File: rtl/seq_mem_rr_arbiter.sv
// Round-robin arbiter sharing one single-port sequential memory between two requesters,
// one transaction in flight, with out-of-range rejection and missing-done detection.
module seq_mem_rr_arbiter #(
  parameter int WIDTH    = 32,
  parameter int SIZE     = 96,
  parameter int IDX_SIZE = 8
) (
  input  logic                clk,
  input  logic                reset,
  seq_mem_rr_arbiter_if.slave bus,
  output logic                proto_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [31:0] SIZE_W = SIZE;

  state_t              state_q, state_d;
  logic                ptr_q, ptr_d;
  logic                id_q, id_d;
  logic                op_q, op_d;
  logic [IDX_SIZE-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]    wdata_q, wdata_d;
  logic [WIDTH-1:0]    rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                proto_err_q, proto_err_d;

  logic                grant_id;
  logic                sel_write;
  logic [IDX_SIZE-1:0] sel_addr;
  logic [WIDTH-1:0]    sel_wdata;
  logic                done_ok;

  logic [1:0]          req_ready_c;
  logic [1:0]          resp_valid_c;
  logic [WIDTH-1:0]    resp_rdata_c;
  logic                resp_err_c;
  logic [IDX_SIZE-1:0] mem_addr0_c;
  logic                mem_read_en_c;
  logic                mem_write_en_c;
  logic [WIDTH-1:0]    mem_in_c;

  // A lone requester always wins; a tie goes to the priority pointer.
  always_comb begin
    grant_id = 1'b0;
    case (bus.req_valid)
      2'b01:   grant_id = 1'b0;
      2'b10:   grant_id = 1'b1;
      2'b11:   grant_id = ptr_q;
      default: grant_id = 1'b0;
    endcase
  end

  assign sel_write = grant_id ? bus.req_write[1] : bus.req_write[0];
  assign sel_addr  = grant_id ? bus.req_addr[2*IDX_SIZE-1:IDX_SIZE] : bus.req_addr[IDX_SIZE-1:0];
  assign sel_wdata = grant_id ? bus.req_wdata[2*WIDTH-1:WIDTH] : bus.req_wdata[WIDTH-1:0];
  assign done_ok   = op_q ? bus.mem_write_done : bus.mem_read_done;

  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    id_d           = id_q;
    op_d           = op_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    rdata_d        = rdata_q;
    err_d          = err_q;
    proto_err_d    = proto_err_q;
    req_ready_c    = 2'b00;
    resp_valid_c   = 2'b00;
    resp_rdata_c   = '0;
    resp_err_c     = 1'b0;
    mem_addr0_c    = '0;
    mem_read_en_c  = 1'b0;
    mem_write_en_c = 1'b0;
    mem_in_c       = '0;

    case (state_q)
      IDLE: begin
        // No grant while reset is held, so every output reads 0 during reset.
        if ((|bus.req_valid) && !reset) begin
          req_ready_c = grant_id ? 2'b10 : 2'b01;
          id_d        = grant_id;
          op_d        = sel_write;
          addr_d      = sel_addr;
          wdata_d     = sel_wdata;
          ptr_d       = ~grant_id;
          rdata_d     = '0;
          if (32'(sel_addr) >= SIZE_W) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            err_d   = 1'b0;
            state_d = ISSUE;
          end
        end
      end

      ISSUE: begin
        mem_addr0_c    = addr_q;
        mem_read_en_c  = ~op_q;
        mem_write_en_c = op_q;
        mem_in_c       = op_q ? wdata_q : '0;
        state_d        = WAIT;
      end

      WAIT: begin
        if (done_ok) begin
          rdata_d = op_q ? '0 : bus.mem_out;
          err_d   = 1'b0;
        end else begin
          rdata_d     = '0;
          err_d       = 1'b1;
          proto_err_d = 1'b1;
        end
        state_d = RESP;
      end

      RESP: begin
        resp_valid_c = id_q ? 2'b10 : 2'b01;
        resp_rdata_c = rdata_q;
        resp_err_c   = err_q;
        if (bus.resp_ready[id_q]) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      id_q        <= 1'b0;
      op_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign bus.req_ready    = req_ready_c;
  assign bus.resp_valid   = resp_valid_c;
  assign bus.resp_rdata   = resp_rdata_c;
  assign bus.resp_err     = resp_err_c;
  assign bus.mem_addr0    = mem_addr0_c;
  assign bus.mem_read_en  = mem_read_en_c;
  assign bus.mem_write_en = mem_write_en_c;
  assign bus.mem_in       = mem_in_c;
  assign proto_err        = proto_err_q;

endmodule

// File: tb/tb_seq_mem_rr_arbiter.sv
// Directed bench for seq_mem_rr_arbiter: a vector table of single transactions plus
// hand-written sequences for alternation, backpressure, reset mid-flight and a lost done.
module tb_seq_mem_rr_arbiter;

  logic clk = 1'b0;
  logic reset;
  logic proto_err;
  logic suppress_rd;
  logic [31:0] mem_arr [0:95];
  int n_checks = 0;
  int n_fail = 0;
  int both_hi = 0;

  typedef struct {
    int          id;
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    bit          exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[12];

  seq_mem_rr_arbiter_if #(.WIDTH(32), .IDX_SIZE(8)) bus ();

  seq_mem_rr_arbiter #(.WIDTH(32), .SIZE(96), .IDX_SIZE(8)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  // Single-port memory: one-cycle access, registered read data, one-cycle done pulses.
  always @(posedge clk) begin
    if (reset) begin
      bus.mem_read_done  <= 1'b0;
      bus.mem_write_done <= 1'b0;
      bus.mem_out        <= '0;
    end else begin
      bus.mem_read_done  <= bus.mem_read_en && !suppress_rd;
      bus.mem_write_done <= bus.mem_write_en;
      if (bus.mem_read_en && bus.mem_addr0 < 8'd96) bus.mem_out <= mem_arr[bus.mem_addr0];
      if (bus.mem_write_en && bus.mem_addr0 < 8'd96) mem_arr[bus.mem_addr0] <= bus.mem_in;
    end
  end

  always @(negedge clk) begin
    if (bus.mem_read_en && bus.mem_write_en) both_hi++;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_req_ready"}, bus.req_ready, 0);
    checkOutput({tag, "_resp_valid"}, bus.resp_valid, 0);
    checkOutput({tag, "_resp_rdata"}, bus.resp_rdata, 0);
    checkOutput({tag, "_resp_err"}, bus.resp_err, 0);
    checkOutput({tag, "_mem_en"}, {bus.mem_read_en, bus.mem_write_en}, 0);
    checkOutput({tag, "_mem_addr0"}, bus.mem_addr0, 0);
    checkOutput({tag, "_mem_in"}, bus.mem_in, 0);
  endtask

  task automatic waitResp(output int lat);
    lat = 1;
    while (bus.resp_valid == 2'b00 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (bus.resp_valid == 2'b00) checkOutput("resp_timeout", 1, 0);
  endtask

  // One complete transaction from a single requester, checked at every stage.
  task automatic applyStimulus(input vec_t v);
    int cyc;
    int lat;
    @(negedge clk);
    bus.req_valid[v.id] = 1'b1;
    bus.req_write[v.id] = v.wr;
    bus.req_addr[v.id*8 +: 8] = v.addr;
    bus.req_wdata[v.id*32 +: 32] = v.wdata;
    #1;
    cyc = 0;
    while (!bus.req_ready[v.id] && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("req_ready", bus.req_ready, 64'(1) << v.id);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid[v.id] = 1'b0;
    if (v.exp_lat == 3) begin
      checkOutput("issue_wr_en", bus.mem_write_en, v.wr);
      checkOutput("issue_rd_en", bus.mem_read_en, !v.wr);
      checkOutput("issue_addr", bus.mem_addr0, v.addr);
      checkOutput("issue_mem_in", bus.mem_in, v.wr ? v.wdata : 32'h0);
    end else begin
      checkOutput("oob_no_mem_en", {bus.mem_read_en, bus.mem_write_en}, 0);
    end
    waitResp(lat);
    checkOutput("resp_latency", lat, v.exp_lat);
    checkOutput("resp_valid", bus.resp_valid, 64'(1) << v.id);
    checkOutput("resp_rdata", bus.resp_rdata, v.exp_rdata);
    checkOutput("resp_err", bus.resp_err, v.exp_err);
    bus.resp_ready[v.id] = 1'b1;
    @(negedge clk);
    bus.resp_ready[v.id] = 1'b0;
    checkOutput("resp_cleared", bus.resp_valid, 0);
  endtask

  // Both requesters read continuously; grants must alternate starting at 'first'.
  task automatic serveBoth(input int n, input int first);
    int cyc;
    int lat;
    logic g;
    @(negedge clk);
    bus.req_valid = 2'b11;
    bus.req_write = 2'b00;
    bus.req_addr = {8'd2, 8'd1};
    bus.resp_ready = 2'b11;
    #1;
    for (int k = 0; k < n; k++) begin
      cyc = 0;
      while (bus.req_ready == 2'b00 && cyc < 20) begin
        @(negedge clk);
        cyc++;
      end
      g = bus.req_ready[1];
      checkOutput("rr_ready_onehot", bus.req_ready, (first + k) % 2 == 1 ? 2'b10 : 2'b01);
      @(posedge clk);
      @(negedge clk);
      waitResp(lat);
      checkOutput("rr_resp_valid", bus.resp_valid, (first + k) % 2 == 1 ? 2'b10 : 2'b01);
      checkOutput("rr_resp_rdata", bus.resp_rdata, g ? 32'h22222222 : 32'h11111111);
    end
    @(negedge clk);
    bus.req_valid = 2'b00;
    bus.resp_ready = 2'b00;
  endtask

  initial begin
    int lat;
    vec_t v;
    vecs[0]  = '{0, 1'b1, 8'd5,   32'hDEADBEEF, 32'h0,        1'b0, 3};
    vecs[1]  = '{0, 1'b0, 8'd5,   32'h0,        32'hDEADBEEF, 1'b0, 3};
    vecs[2]  = '{1, 1'b0, 8'd96,  32'h0,        32'h0,        1'b1, 1};
    vecs[3]  = '{1, 1'b1, 8'd95,  32'h12345678, 32'h0,        1'b0, 3};
    vecs[4]  = '{1, 1'b0, 8'd95,  32'h0,        32'h12345678, 1'b0, 3};
    vecs[5]  = '{0, 1'b1, 8'd255, 32'hFFFF0000, 32'h0,        1'b1, 1};
    vecs[6]  = '{1, 1'b1, 8'd0,   32'hA5A5A5A5, 32'h0,        1'b0, 3};
    vecs[7]  = '{0, 1'b0, 8'd0,   32'h0,        32'hA5A5A5A5, 1'b0, 3};
    vecs[8]  = '{0, 1'b1, 8'd1,   32'h11111111, 32'h0,        1'b0, 3};
    vecs[9]  = '{1, 1'b1, 8'd2,   32'h22222222, 32'h0,        1'b0, 3};
    vecs[10] = '{1, 1'b0, 8'd1,   32'h0,        32'h11111111, 1'b0, 3};
    vecs[11] = '{0, 1'b0, 8'd95,  32'h0,        32'h12345678, 1'b0, 3};

    reset = 1'b1;
    suppress_rd = 1'b0;
    bus.req_valid = '0;
    bus.req_write = '0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    bus.resp_ready = '0;
    for (int i = 0; i < 96; i++) mem_arr[i] = 32'h0;

    repeat (2) @(negedge clk);
    checkIdleOutputs("reset");
    checkOutput("reset_proto_err", proto_err, 0);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) applyStimulus(vecs[i]);
    checkOutput("proto_err_clean", proto_err, 0);

    $display("[TB] alternating grants from reset");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    serveBoth(4, 0);

    $display("[TB] response backpressure");
    @(negedge clk);
    bus.req_valid = 2'b11;
    bus.req_write = 2'b00;
    bus.req_addr = {8'd2, 8'd5};
    #1;
    checkOutput("bp_grant0", bus.req_ready, 2'b01);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid[0] = 1'b0;
    waitResp(lat);
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_hold_valid", bus.resp_valid, 2'b01);
      checkOutput("bp_hold_rdata", bus.resp_rdata, 32'hDEADBEEF);
      checkOutput("bp_no_ready", bus.req_ready, 2'b00);
      @(negedge clk);
    end
    bus.resp_ready[0] = 1'b1;
    @(negedge clk);
    bus.resp_ready[0] = 1'b0;
    checkOutput("bp_release_valid", bus.resp_valid, 2'b00);
    checkOutput("bp_grant1", bus.req_ready, 2'b10);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid[1] = 1'b0;
    bus.resp_ready[1] = 1'b1;
    waitResp(lat);
    checkOutput("bp_resp1_valid", bus.resp_valid, 2'b10);
    checkOutput("bp_resp1_rdata", bus.resp_rdata, 32'h22222222);
    @(negedge clk);
    bus.resp_ready = 2'b00;

    $display("[TB] reset during WAIT");
    bus.req_valid[0] = 1'b1;
    bus.req_write[0] = 1'b1;
    bus.req_addr[7:0] = 8'd10;
    bus.req_wdata[31:0] = 32'hCAFEF00D;
    #1;
    checkOutput("rst_grant0", bus.req_ready, 2'b01);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid[0] = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkIdleOutputs("midrst");
    bus.req_valid = 2'b11;
    bus.req_write = 2'b00;
    bus.req_addr = {8'd2, 8'd1};
    #1;
    checkOutput("midrst_ready_gated", bus.req_ready, 2'b00);
    @(negedge clk);
    reset = 1'b0;
    bus.req_valid = 2'b00;
    serveBoth(2, 0);

    $display("[TB] missing read_done");
    @(negedge clk);
    suppress_rd = 1'b1;
    v = '{1, 1'b0, 8'd95, 32'h0, 32'h0, 1'b1, 3};
    applyStimulus(v);
    suppress_rd = 1'b0;
    checkOutput("proto_err_set", proto_err, 1);
    applyStimulus(vecs[1]);
    checkOutput("proto_err_sticky", proto_err, 1);

    checkOutput("enables_exclusive", both_hi, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_mem_rr_arbiter.md
Name: seq_mem_rr_arbiter

Overview:
Shares one single-port sequential memory (one-cycle read/write, registered read data, read_done/write_done pulses, simultaneous read+write forbidden) between two requesters. Each requester uses a valid/ready request channel and a valid/ready response channel. Arbitration is round-robin with one transaction in flight. Out-of-range addresses are rejected before they reach the memory. Sits between two compute-group controllers and the memory instance.

Parameters:
WIDTH, 32, data word width
SIZE, 96, number of memory words
IDX_SIZE, 8, address width

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
req_valid  input  2  per-requester request valid (bit i = requester i)
req_ready  output  2  per-requester request accept
req_write  input  2  per-requester op: 1 = write, 0 = read
req_addr  input  2*IDX_SIZE  requester i address at [i*IDX_SIZE +: IDX_SIZE]
req_wdata  input  2*WIDTH  requester i write data at [i*WIDTH +: WIDTH]
resp_valid  output  2  per-requester response valid
resp_ready  input  2  per-requester response accept
resp_rdata  output  WIDTH  read data for the responding requester; 0 for writes and errors
resp_err  output  1  response carries an error (bad address or missing done)
mem_addr0  output  IDX_SIZE  memory address
mem_read_en  output  1  memory read enable
mem_write_en  output  1  memory write enable
mem_in  output  WIDTH  memory write data
mem_out  input  WIDTH  memory registered read data
mem_read_done  input  1  memory read completion
mem_write_done  input  1  memory write completion
proto_err  output  1  sticky flag: expected done pulse was not received

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP.
- Reset: state IDLE; all outputs 0; round-robin priority pointer = 0; proto_err = 0.
- IDLE arbitration:
  - If exactly one req_valid is high, grant that requester.
  - If both are high, grant the requester named by the priority pointer.
  - req_ready is combinational: high only for the granted requester, and only in IDLE.
  - On the handshake, latch id, op, address and wdata. Set pointer = the other requester (1 - id).
  - If the address >= SIZE: no memory access; go to RESP with resp_err = 1 and rdata 0.
  - Otherwise go to ISSUE.
- ISSUE (exactly one cycle):
  - Drive mem_addr0 with the latched address.
  - Drive mem_read_en = !op and mem_write_en = op.
  - Drive mem_in with the latched wdata for writes, 0 for reads.
  - Go to WAIT.
- Enable invariants: mem_read_en and mem_write_en are never high in the same cycle. Both are 0 in every state other than ISSUE.
- WAIT (one cycle):
  - Sample the done signal matching op. On a read, also capture mem_out into the response register.
  - If the matching done is absent: set proto_err, and set resp_err = 1 with rdata 0.
  - Go to RESP.
- RESP:
  - Hold resp_valid[id] = 1, with resp_rdata and resp_err stable, until resp_ready[id].
  - On the handshake, clear resp_valid and go to IDLE. A new grant is possible in the next cycle.
  - resp_valid is never high for both requesters at once.
- Latency: request handshake to resp_valid = 3 cycles for an in-range access, 1 cycle for an out-of-range one. Best-case throughput is one transaction per 4 cycles.
- Requester obligation: request fields stay stable while valid && !ready. The arbiter samples them only at the handshake.
- Reset mid-operation: the in-flight transaction is dropped with no response. The memory may already have committed a write from ISSUE. proto_err is cleared only by reset.

Test Plan:
- Requester 0 writes 0xDEADBEEF to addr 5, then reads addr 5 -> ISSUE cycle shows mem_write_en=1, mem_addr0=5, mem_in=0xDEADBEEF; read response has resp_valid[0]=1, resp_rdata=0xDEADBEEF, resp_err=0, 3 cycles after the handshake.
- Both requesters hold reads (addrs 1 and 2) continuously from reset -> grants alternate 0,1,0,1; responses return to the matching resp_valid bit; memory enables are never both high.
- Requester 1 reads addr 96 (SIZE) -> no memory enable asserted; resp_valid[1]=1 with resp_err=1 and resp_rdata=0 one cycle after the handshake.
- resp_ready[0] held low 5 cycles during RESP -> resp_valid/resp_rdata stay stable; req_ready stays 0 for both requesters; on release, IDLE resumes and grants requester 1 if it is pending.
- Reset asserted during WAIT -> next cycle all outputs 0 and state IDLE; no response is delivered; after release, requester 0 wins a simultaneous request.
- Memory model suppresses read_done once -> proto_err=1 (sticky), response has resp_err=1 and rdata 0; later transactions complete normally.
